mux4x1_rr_arb: RTL and testbench
================================

# mux4x1_rr_arb

Round-robin arbiter and sequencer that shares the team's 4:1 single-bit multiplexer between four requesters. It selects one requester at a time, drives the mux select pair `s1`/`s0` in the mux's native encoding, and bounds each ownership with a hold timeout. It also provides a registered copy of the selected input with a valid flag. It sits directly in front of a `mux4x1` instance, or replaces its select logic, wherever a single output line is time-shared.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one requester may own the mux; legal range 1..255.
- `clk`  input  1: single clock, all state updates on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `req`  input  4: request per requester, bit k = requester k; level-sensitive.
- `i`  input  4: data bits, bit k belongs to requester k.
- `gnt`  output  4: one-hot grant, registered; all-zero when no owner.
- `s1`  output  1: mux select, high bit, registered.
- `s0`  output  1: mux select, low bit, registered.
- `busy`  output  1: high while any grant is active; equals `|gnt`.
- `y`  output  1: registered selected data.
- `vld`  output  1: high when `y` carries data from a granted requester.

## Operation
- Select encoding is fixed by the mux: owner index k drives {s1,s0} = 3-k, so 0→11, 1→10, 2→01, 3→00.
- The FSM has two states.
  - IDLE: gnt=0. On an edge where `req`≠0, move to GRANT. The owner is the first set `req` bit at or after `ptr`, searching upward with wrap 3→0.
  - GRANT: the owner keeps `gnt` while `req[owner]`=1 and `cnt`<MAX_HOLD-1.
- Release condition: `req[owner]`=0, or `cnt`=MAX_HOLD-1.
- On release, the block re-arbitrates in the same edge. The search starts at owner+1 and includes the owner itself last.
  - Any candidate found: `gnt` switches directly to it with no idle cycle, and `cnt` is cleared.
  - No candidate: go to IDLE with gnt=0.
- Timeout with only the owner requesting: the same owner is re-granted and `cnt` cleared. Others requesting: ownership rotates.
- `ptr` takes the value (new owner+1) mod 4 on every grant, so the last winner has lowest priority.
- `cnt` is 8 bits. It increments each GRANT cycle without a release and never wraps, because it is cleared at MAX_HOLD-1.
- `s1`/`s0` update together with `gnt`. In IDLE they hold the last owner's code, so there are no glitches on the mux.
- `y` loads i[owner] using the current `gnt`, one cycle later. `vld` follows `busy` one cycle later. `y` holds its value when `vld`=0.
- MAX_HOLD=1: every grant lasts exactly one cycle, giving pure round-robin per cycle.

## Timing
- Reset values: gnt=0000, busy=0, {s1,s0}=11, y=0, vld=0, ptr=0, cnt=0, state=IDLE.
- Reset takes priority over every event. Asserted mid-grant, it drops `gnt` on that edge.
- Request-to-grant latency: `req` sampled at edge N gives `gnt` visible after edge N.
- Grant-to-data latency: 1 cycle. The `y`/`vld` pair at cycle N+1 reflects the owner and `i` of cycle N.
- Handover when another request is pending: 0 idle cycles. `gnt` changes from one-hot A to one-hot B in a single edge.
- A requester that drops `req` loses `gnt` on the next edge, so it may own the mux for one extra cycle after deasserting.
- Requests that arrive while another requester owns the mux wait; they are never lost while held high.
- Requests asserted and dropped between edges are not seen.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with req=1111. Required: gnt=0000, {s1,s0}=11, vld=0, y=0 throughout. Then release.
- Single requester: req=0100 held for 3 cycles, then 0000.
  - Required: gnt=0100 and {s1,s0}=01 one edge after the request, held 3 cycles; vld=1 one cycle later.
  - Required: then gnt=0000, and {s1,s0} stays 01.
- Rotation with MAX_HOLD=1: req=1111 held.
  - Required: gnt sequence 0001, 0010, 0100, 1000, 0001.
  - Required: {s1,s0} sequence 11, 10, 01, 00, 11.
- Timeout with MAX_HOLD=4: req=0011 held.
  - Required: gnt=0001 for exactly 4 cycles, then 0010 for 4, then 0001 again, with no gap cycles.
- Solo timeout and data path with MAX_HOLD=4: req=1000 only, i[3] toggling each cycle.
  - Required: gnt stays 1000 continuously (re-grant).
  - Required: y equals i[3] delayed one cycle, and vld=1.
- Mid-operation reset: while gnt=0010, pulse `rst` for 1 cycle.
  - Required: next gnt=0000, ptr=0.
  - Required: with req=0011 afterwards, first grant is 0001.

Source files
------------

// File: rtl/mux4x1_rr_arb.sv
// Round-robin owner selection for a shared 4:1 mux, with hold timeout
// and a registered copy of the selected data bit.
`timescale 1ns/1ps
module mux4x1_rr_arb #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] i,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic       y,
  output logic       vld
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] owner;
  logic [7:0] cnt;

  logic       rel;
  logic       take;
  logic [1:0] start;
  logic [2:0] cand;

  // {found, index}: first set bit at or after start, wrapping 3->0
  function automatic logic [2:0] pick(
    input logic [3:0] r,
    input logic [1:0] st
  );
    logic [2:0] res;
    logic [1:0] k;
    res = '0;
    for (int n = 3; n >= 0; n--) begin
      k = st + 2'(n);
      if (r[k]) res = {1'b1, k};
    end
    return res;
  endfunction

  always_comb begin
    rel   = 1'b0;
    start = ptr;
    if (state == GRANT) begin
      rel   = !req[owner] || (cnt == HOLD_LAST);
      start = owner + 2'd1;
    end
    cand = pick(req, start);
    take = cand[2] && ((state == IDLE) || rel);
  end

  assign busy = |gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      owner    <= 2'd0;
      cnt      <= 8'd0;
      gnt      <= 4'b0000;
      {s1, s0} <= 2'b11;
      y        <= 1'b0;
      vld      <= 1'b0;
    end else begin
      vld <= busy;
      if (busy) y <= i[owner];
      // select code 3-k is the bitwise inverse of k
      if (take) begin
        state    <= GRANT;
        owner    <= cand[1:0];
        gnt      <= 4'b0001 << cand[1:0];
        {s1, s0} <= ~cand[1:0];
        ptr      <= cand[1:0] + 2'd1;
        cnt      <= 8'd0;
      end else if (state == GRANT) begin
        if (rel) begin
          state <= IDLE;
          gnt   <= 4'b0000;
          cnt   <= 8'd0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux4x1_rr_arb.sv
// Scoreboard bench for mux4x1_rr_arb at MAX_HOLD 8, 1 and 4.
`timescale 1ns/1ps
module tb_mux4x1_rr_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] i;

  logic [3:0] g8, g1, g4;
  logic       s1_8, s0_8, s1_1, s0_1, s1_4, s0_4;
  logic       b8, b1, b4;
  logic       y8, y1, y4;
  logic       v8, v1, v4;

  always #5 clk = ~clk;

  mux4x1_rr_arb #(.MAX_HOLD(8)) u_mh8 (
    .clk(clk), .rst(rst), .req(req), .i(i),
    .gnt(g8), .s1(s1_8), .s0(s0_8),
    .busy(b8), .y(y8), .vld(v8)
  );

  mux4x1_rr_arb #(.MAX_HOLD(1)) u_mh1 (
    .clk(clk), .rst(rst), .req(req), .i(i),
    .gnt(g1), .s1(s1_1), .s0(s0_1),
    .busy(b1), .y(y1), .vld(v1)
  );

  mux4x1_rr_arb #(.MAX_HOLD(4)) u_mh4 (
    .clk(clk), .rst(rst), .req(req), .i(i),
    .gnt(g4), .s1(s1_4), .s0(s0_4),
    .busy(b4), .y(y4), .vld(v4)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       y;
    logic       vld;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   dut_sel = 8;

  logic [3:0] m_gnt;
  logic [1:0] m_sel;
  logic       m_y;

  logic [3:0] o_gnt;
  logic [1:0] o_sel;
  logic       o_busy, o_y, o_vld;

  always_comb begin
    o_gnt  = g8;
    o_sel  = {s1_8, s0_8};
    o_busy = b8;
    o_y    = y8;
    o_vld  = v8;
    case (dut_sel)
      1: begin
        o_gnt = g1; o_sel = {s1_1, s0_1};
        o_busy = b1; o_y = y1; o_vld = v1;
      end
      4: begin
        o_gnt = g4; o_sel = {s1_4, s0_4};
        o_busy = b4; o_y = y4; o_vld = v4;
      end
      default: ;
    endcase
  end

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] sel_code(input logic [3:0] g);
    logic [1:0] c;
    c = 2'b11;
    for (int k = 0; k < 4; k++)
      if (g[k]) c = 2'(3 - k);
    return c;
  endfunction

  task automatic cyc(
    input logic       r,
    input logic [3:0] rq,
    input logic [3:0] d,
    input logic [3:0] eg
  );
    exp_t e;
    exp_t o;
    rst = r;
    req = rq;
    i   = d;
    e   = '0;
    if (r) begin
      e.sel = 2'b11;
    end else begin
      e.vld = |m_gnt;
      e.y   = (|m_gnt) ? |(m_gnt & d) : m_y;
      e.gnt = eg;
      e.sel = (|eg) ? sel_code(eg) : m_sel;
    end
    m_gnt = e.gnt;
    m_sel = e.sel;
    m_y   = e.y;
    q.push_back(e);
    @(posedge clk);
    #1;
    o = q.pop_front();
    chk("gnt", 8'(o_gnt), 8'(o.gnt));
    chk("sel", 8'(o_sel), 8'(o.sel));
    chk("busy", 8'(o_busy), 8'(|o.gnt));
    chk("vld", 8'(o_vld), 8'(o.vld));
    chk("y", 8'(o_y), 8'(o.y));
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    i   = 4'b0000;
    m_gnt = '0;
    m_sel = 2'b11;
    m_y   = 1'b0;
    @(posedge clk);
    #1;

    // reset with all requesting, then single requester 2
    dut_sel = 8;
    repeat (2) cyc(1'b1, 4'b1111, 4'b1111, 4'b0000);
    chk("ptr_rst", 8'(u_mh8.ptr), 8'd0);
    chk("cnt_rst", u_mh8.cnt, 8'd0);
    repeat (3) cyc(1'b0, 4'b0100, 4'b0100, 4'b0100);
    repeat (2) cyc(1'b0, 4'b0000, 4'b0100, 4'b0000);

    // per-cycle rotation
    dut_sel = 1;
    cyc(1'b1, 4'b0000, 4'b0000, 4'b0000);
    cyc(1'b0, 4'b1111, 4'b1010, 4'b0001);
    cyc(1'b0, 4'b1111, 4'b1010, 4'b0010);
    cyc(1'b0, 4'b1111, 4'b1010, 4'b0100);
    cyc(1'b0, 4'b1111, 4'b1010, 4'b1000);
    cyc(1'b0, 4'b1111, 4'b1010, 4'b0001);

    // timeout handover between two requesters
    dut_sel = 4;
    cyc(1'b1, 4'b0000, 4'b0000, 4'b0000);
    repeat (4) cyc(1'b0, 4'b0011, 4'b0110, 4'b0001);
    repeat (4) cyc(1'b0, 4'b0011, 4'b0110, 4'b0010);
    repeat (2) cyc(1'b0, 4'b0011, 4'b0110, 4'b0001);

    // solo timeout re-grant, data path follows i[3]
    cyc(1'b1, 4'b0000, 4'b0000, 4'b0000);
    for (int n = 0; n < 10; n++)
      cyc(1'b0, 4'b1000, {n[0], 3'b101}, 4'b1000);
    cyc(1'b0, 4'b0000, 4'b0111, 4'b0000);
    cyc(1'b0, 4'b0000, 4'b1000, 4'b0000);

    // reset mid-grant
    dut_sel = 8;
    cyc(1'b1, 4'b0000, 4'b0000, 4'b0000);
    repeat (2) cyc(1'b0, 4'b0010, 4'b0010, 4'b0010);
    chk("ptr_pre", 8'(u_mh8.ptr), 8'd2);
    cyc(1'b1, 4'b0010, 4'b0010, 4'b0000);
    chk("ptr_mid", 8'(u_mh8.ptr), 8'd0);
    repeat (2) cyc(1'b0, 4'b0011, 4'b0001, 4'b0001);

    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
